// File: rtl/ecc_apb_job_driver_pkg.sv
// Shared constants and types for the ECC APB job driver: register map,
// mode/width encodings and the FSM state encoding.
package ecc_apb_job_driver_pkg;

  localparam logic [3:0] REG_CTRL           = 4'h0;
  localparam logic [3:0] REG_DATA_IN        = 4'h4;
  localparam logic [3:0] REG_CODEWORD_WIDTH = 4'h8;
  localparam logic [3:0] REG_NOISE          = 4'hC;

  typedef enum logic [1:0] {
    MODE_ENCODE       = 2'b00,
    MODE_DECODE       = 2'b01,
    MODE_FULL_CHANNEL = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    WIDTH_SMALL  = 2'b00,
    WIDTH_MEDIUM = 2'b01,
    WIDTH_LARGE  = 2'b10
  } width_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESULT    = 3'd4
  } state_e;

  // Write order of the register programming sequence; CTRL is always last.
  typedef enum logic [1:0] {
    WR_DATA_IN        = 2'd0,
    WR_CODEWORD_WIDTH = 2'd1,
    WR_NOISE          = 2'd2,
    WR_CTRL           = 2'd3
  } wr_idx_e;

  // The reserved mode 11 behaves as full channel.
  function automatic mode_e norm_mode(input logic [1:0] ctrl);
    return ctrl[1] ? MODE_FULL_CHANNEL : mode_e'(ctrl);
  endfunction

  function automatic logic [3:0] reg_offset(input wr_idx_e idx);
    case (idx)
      WR_DATA_IN:        return REG_DATA_IN;
      WR_CODEWORD_WIDTH: return REG_CODEWORD_WIDTH;
      WR_NOISE:          return REG_NOISE;
      default:           return REG_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_job_driver_if.sv
// APB write-only bus between the job driver (master) and the ECC register block.
interface ecc_apb_job_driver_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) ();
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;

  modport master (output PADDR, PWDATA, PSEL, PENABLE, PWRITE);
  modport slave  (input  PADDR, PWDATA, PSEL, PENABLE, PWRITE);
endinterface

// File: rtl/ecc_apb_write_seq.sv
// APB SETUP/ACCESS sequencer: latches a job on start and walks the register
// writes, skipping NOISE unless the job is full channel.
module ecc_apb_write_seq
  import ecc_apb_job_driver_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int BASE_ADDR       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           job_ctrl,
  input  logic [1:0]           job_width,
  input  logic [AMBA_WORD-1:0] job_data,
  input  logic [AMBA_WORD-1:0] job_noise,
  output logic                 last_done,
  ecc_apb_job_driver_if.master apb
);

  localparam logic [AMBA_ADDR_WIDTH-1:0] BASE = AMBA_ADDR_WIDTH'(BASE_ADDR);

  state_e                     phase_q, phase_d;
  wr_idx_e                    idx_q, idx_d;
  mode_e                      mode_q, mode_d;
  logic [1:0]                 width_q, width_d;
  logic [AMBA_WORD-1:0]       data_q, data_d;
  logic [AMBA_WORD-1:0]       noise_q, noise_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic                       load;

  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    width_d   = width_q;
    data_d    = data_q;
    noise_d   = noise_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    load      = 1'b0;

    case (phase_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = norm_mode(job_ctrl);
          width_d = job_width;
          data_d  = job_data;
          noise_d = job_noise;
          idx_d   = WR_DATA_IN;
          phase_d = ST_SETUP;
          load    = 1'b1;
        end
      end
      ST_SETUP: begin
        phase_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (idx_q == WR_CTRL) begin
          phase_d   = ST_IDLE;
          paddr_d   = '0;
          pwdata_d  = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
        end else begin
          if (idx_q == WR_DATA_IN)
            idx_d = WR_CODEWORD_WIDTH;
          else if (idx_q == WR_CODEWORD_WIDTH && mode_q == MODE_FULL_CHANNEL)
            idx_d = WR_NOISE;
          else
            idx_d = WR_CTRL;
          phase_d = ST_SETUP;
          load    = 1'b1;
        end
      end
      default: phase_d = ST_IDLE;
    endcase

    // Address and data for the next SETUP come from the freshly selected index.
    if (load) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      paddr_d   = BASE + AMBA_ADDR_WIDTH'(reg_offset(idx_d));
      case (idx_d)
        WR_DATA_IN:        pwdata_d = data_d;
        WR_CODEWORD_WIDTH: pwdata_d = {{(AMBA_WORD-2){1'b0}}, width_d};
        WR_NOISE:          pwdata_d = noise_d;
        default:           pwdata_d = {{(AMBA_WORD-2){1'b0}}, mode_d};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= ST_IDLE;
      idx_q     <= WR_DATA_IN;
      mode_q    <= MODE_ENCODE;
      width_q   <= '0;
      data_q    <= '0;
      noise_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      width_q   <= width_d;
      data_q    <= data_d;
      noise_q   <= noise_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
    end
  end

  assign last_done   = (phase_q == ST_ACCESS) && (idx_q == WR_CTRL);
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;

endmodule

// File: rtl/ecc_apb_job_driver.sv
// Job-level controller: accepts a job, lets the write sequencer program the
// ECC block, then waits for operation_done (with watchdog) and holds the result.
module ecc_apb_job_driver
  import ecc_apb_job_driver_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BASE_ADDR       = 0,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [1:0]            job_ctrl,
  input  logic [1:0]            job_width,
  input  logic [AMBA_WORD-1:0]  job_data,
  input  logic [AMBA_WORD-1:0]  job_noise,
  ecc_apb_job_driver_if.master  apb,
  input  logic                  operation_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [1:0]            num_of_errors,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [1:0]            res_errors,
  output logic                  res_timeout,
  output logic                  busy
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            wd_q, wd_d;
  logic                  job_ready_q, job_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [1:0]            res_errors_q, res_errors_d;
  logic                  res_timeout_q, res_timeout_d;
  logic                  busy_q, busy_d;
  logic                  start;
  logic                  last_done;

  assign start = (state_q == ST_IDLE) && job_valid && job_ready_q;

  ecc_apb_write_seq #(
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
    .AMBA_WORD       (AMBA_WORD),
    .BASE_ADDR       (BASE_ADDR)
  ) u_write_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .job_ctrl  (job_ctrl),
    .job_width (job_width),
    .job_data  (job_data),
    .job_noise (job_noise),
    .last_done (last_done),
    .apb       (apb)
  );

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_errors_d  = res_errors_q;
    res_timeout_d = res_timeout_q;

    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (last_done) begin
          state_d = ST_WAIT_DONE;
          wd_d    = '0;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_WAIT_DONE: begin
        // A done pulse wins over a watchdog expiry in the same cycle.
        if (operation_done) begin
          res_data_d    = data_out;
          res_errors_d  = num_of_errors;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = ST_RESULT;
        end else if (wd_q == WD_LAST) begin
          res_data_d    = '0;
          res_errors_d  = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = ST_RESULT;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      ST_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    job_ready_d = (state_d == ST_IDLE) && !res_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wd_q          <= '0;
      job_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_errors_q  <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      job_ready_q   <= job_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_errors_q  <= res_errors_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign job_ready   = job_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_errors  = res_errors_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ecc_apb_job_driver.sv
// Scoreboard bench for ecc_apb_job_driver: expected APB writes and results are
// queued by the stimulus and popped by independent bus/result monitors.
module tb_ecc_apb_job_driver;

  localparam int AW = 20;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    errs;
    logic          to;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [1:0]    job_ctrl = '0;
  logic [1:0]    job_width = '0;
  logic [31:0]   job_data = '0;
  logic [31:0]   job_noise = '0;
  logic          operation_done = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic [1:0]    num_of_errors = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [1:0]    res_errors;
  logic          res_timeout;
  logic          busy;

  wr_t  apb_q[$];
  res_t res_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pen_cnt = 0;

  always #5 clk = ~clk;

  ecc_apb_job_driver_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32)) apb_if ();

  ecc_apb_job_driver #(
    .AMBA_ADDR_WIDTH (AW),
    .AMBA_WORD       (32),
    .DATA_WIDTH      (DW),
    .BASE_ADDR       (0),
    .TIMEOUT_CYCLES  (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_ctrl       (job_ctrl),
    .job_width      (job_width),
    .job_data       (job_data),
    .job_noise      (job_noise),
    .apb            (apb_if),
    .operation_done (operation_done),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_errors     (res_errors),
    .res_timeout    (res_timeout),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  // APB monitor: every ACCESS cycle is one completed write.
  always @(negedge clk) begin : apb_mon
    wr_t e;
    if (rst && apb_if.PSEL && apb_if.PENABLE) begin
      pen_cnt++;
      if (apb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL apb_unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 apb_if.PADDR, apb_if.PWDATA);
      end else begin
        e = apb_q.pop_front();
        chk("apb_addr", 64'(apb_if.PADDR), 64'(e.addr));
        chk("apb_data", 64'(apb_if.PWDATA), 64'(e.data));
        chk("apb_pwrite", 64'(apb_if.PWRITE), 64'd1);
      end
    end
  end

  // Result monitor: compares once per res_valid & res_ready handshake.
  always @(negedge clk) begin : res_mon
    res_t e;
    if (rst && res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got data 0x%0h, expected no result", res_data);
      end else begin
        e = res_q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_errors", 64'(res_errors), 64'(e.errs));
        chk("res_timeout", 64'(res_timeout), 64'(e.to));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d);
    apb_q.push_back('{addr: a, data: d});
  endtask

  task automatic exp_res(input logic [DW-1:0] d, input logic [1:0] e, input logic t);
    res_q.push_back('{data: d, errs: e, to: t});
  endtask

  task automatic send_job(input logic [1:0] c, input logic [1:0] w,
                          input logic [31:0] d, input logic [31:0] n);
    bit ok = 0;
    job_ctrl  = c;
    job_width = w;
    job_data  = d;
    job_noise = n;
    job_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (job_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("job_handshake");
    tick();
    job_valid = 1'b0;
    // Garbage after the handshake must not leak into the register writes.
    job_ctrl  = 2'b01;
    job_width = 2'b11;
    job_data  = 32'hDEAD_BEEF;
    job_noise = 32'hFFFF_FFFF;
  endtask

  task automatic wait_ctrl_write();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (apb_if.PSEL && apb_if.PENABLE && apb_if.PADDR == '0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("ctrl_write");
  endtask

  task automatic pulse_done(input logic [DW-1:0] d, input logic [1:0] e);
    tick();
    operation_done = 1'b1;
    data_out       = d;
    num_of_errors  = e;
    tick();
    operation_done = 1'b0;
  endtask

  task automatic wait_res();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("res_valid");
  endtask

  task automatic consume();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    bound_fail("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stim
    int n;
    // Reset values
    @(negedge clk);
    chk("rst_psel", 64'(apb_if.PSEL), 64'd0);
    chk("rst_penable", 64'(apb_if.PENABLE), 64'd0);
    chk("rst_pwrite", 64'(apb_if.PWRITE), 64'd0);
    chk("rst_paddr", 64'(apb_if.PADDR), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_job_ready", 64'(job_ready), 64'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_job_ready", 64'(job_ready), 64'd1);
    tick();

    // Encode, small width: NOISE write skipped
    pen_cnt = 0;
    exp_wr(20'h4, 32'h5);
    exp_wr(20'h8, 32'h0);
    exp_wr(20'h0, 32'h0);
    exp_res(32'h5A, 2'd0, 1'b0);
    send_job(2'b00, 2'b00, 32'h5, 32'h0);
    wait_ctrl_write();
    pulse_done(32'h5A, 2'd0);
    wait_res();
    consume();
    chk("enc_penable_cycles", 64'(pen_cnt), 64'd3);

    // Full channel with NOISE
    exp_wr(20'h4, 32'h0123_4567);
    exp_wr(20'h8, 32'h2);
    exp_wr(20'hC, 32'h3);
    exp_wr(20'h0, 32'h2);
    exp_res(32'h0BAD_F00D, 2'd2, 1'b0);
    send_job(2'b10, 2'b10, 32'h0123_4567, 32'h0000_0003);
    wait_ctrl_write();
    pulse_done(32'h0BAD_F00D, 2'd2);
    wait_res();
    consume();

    // Mode 11 behaves as full channel, CTRL written as 10
    exp_wr(20'h4, 32'h1);
    exp_wr(20'h8, 32'h0);
    exp_wr(20'hC, 32'h80);
    exp_wr(20'h0, 32'h2);
    exp_res(32'h11, 2'd1, 1'b0);
    send_job(2'b11, 2'b00, 32'h1, 32'h80);
    wait_ctrl_write();
    pulse_done(32'h11, 2'd1);
    wait_res();
    consume();

    // Timeout: no done; data_out driven non-zero must not be captured
    data_out      = 32'hFFFF_FFFF;
    num_of_errors = 2'd2;
    exp_wr(20'h4, 32'h99);
    exp_wr(20'h8, 32'h1);
    exp_wr(20'h0, 32'h1);
    exp_res(32'h0, 2'd0, 1'b1);
    send_job(2'b01, 2'b01, 32'h99, 32'h0);
    wait_ctrl_write();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (res_valid) begin
        n = i;
        break;
      end
    end
    // One edge to enter WAIT_DONE, then 15 watchdog cycles
    chk("timeout_latency", 64'(n), 64'd16);
    consume();

    // Backpressure with job_valid held high
    exp_wr(20'h4, 32'h7);
    exp_wr(20'h8, 32'h0);
    exp_wr(20'h0, 32'h0);
    exp_res(32'h66, 2'd1, 1'b0);
    send_job(2'b00, 2'b00, 32'h7, 32'h0);
    wait_ctrl_write();
    pulse_done(32'h66, 2'd1);
    wait_res();
    tick();
    job_ctrl  = 2'b01;
    job_width = 2'b01;
    job_data  = 32'hABCD;
    job_noise = 32'h0;
    job_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_job_ready", 64'(job_ready), 64'd0);
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      chk("bp_res_data", 64'(res_data), 64'h66);
      chk("bp_res_errors", 64'(res_errors), 64'd1);
    end
    exp_wr(20'h4, 32'hABCD);
    exp_wr(20'h8, 32'h1);
    exp_wr(20'h0, 32'h1);
    exp_res(32'h77, 2'd1, 1'b0);
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_consume", 64'(job_ready), 64'd1);
    chk("bp_valid_cleared", 64'(res_valid), 64'd0);
    tick();
    job_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_job_busy", 64'(busy), 64'd1);
    chk("bp_next_job_ready", 64'(job_ready), 64'd0);
    wait_ctrl_write();
    pulse_done(32'h77, 2'd1);
    wait_res();
    consume();

    // Reset asserted asynchronously during an ACCESS cycle
    exp_wr(20'h4, 32'h3);
    send_job(2'b00, 2'b00, 32'h3, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (apb_if.PENABLE) begin
        n = 1;
        break;
      end
    end
    if (n == 0) bound_fail("penable_for_reset");
    #1 rst = 1'b0;
    #1;
    chk("arst_psel", 64'(apb_if.PSEL), 64'd0);
    chk("arst_penable", 64'(apb_if.PENABLE), 64'd0);
    chk("arst_pwrite", 64'(apb_if.PWRITE), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    apb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_release_job_ready", 64'(job_ready), 64'd1);
    chk("arst_release_busy", 64'(busy), 64'd0);

    // Spurious operation_done in IDLE
    tick();
    operation_done = 1'b1;
    data_out       = 32'h1;
    tick();
    operation_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_res_valid", 64'(res_valid), 64'd0);
      chk("spur_busy", 64'(busy), 64'd0);
      chk("spur_job_ready", 64'(job_ready), 64'd1);
    end

    chk("apb_queue_drained", 64'(apb_q.size()), 64'd0);
    chk("res_queue_drained", 64'(res_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
